// File: rtl/ibex_fetch_fifo_pkg.sv
// ============================================================================
// Module      : ibex_fetch_fifo_pkg
// Description : Shared types and helpers for the instruction fetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_fetch_fifo_pkg;

  localparam int unsigned FETCH_FIFO_HALF_W = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_fifo_entry_t;

  // A halfword opens a 16-bit instruction unless its two low bits are both set.
  function automatic logic is_compressed(input logic [FETCH_FIFO_HALF_W-1:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_fetch_fifo_align.sv
// ============================================================================
// Module      : ibex_fetch_fifo_align
// Description : Combinational realignment of the two oldest fetch words into
//               one instruction with error attribution.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_fetch_fifo_align
  import ibex_fetch_fifo_pkg::*;
(
  input  fetch_fifo_entry_t i_entry0,
  input  fetch_fifo_entry_t i_entry1,
  input  logic              i_valid0,
  input  logic              i_valid1,
  input  logic              i_addr_bit1,
  output logic [31:0]       o_instr,
  output logic              o_valid,
  output logic              o_err,
  output logic              o_err_plus2,
  output logic              o_is_compressed,
  output logic              o_pop
);

  logic [FETCH_FIFO_HALF_W-1:0] w_lower;
  logic [FETCH_FIFO_HALF_W-1:0] w_unused_hi;
  logic                         w_err;

  assign w_lower     = i_entry0.rdata[31:16];
  assign w_unused_hi = i_entry1.rdata[31:16];

  always_comb begin
    o_instr         = i_entry0.rdata;
    o_valid         = 1'b0;
    w_err           = 1'b0;
    o_err_plus2     = 1'b0;
    o_is_compressed = 1'b0;
    o_pop           = 1'b0;

    if (!i_addr_bit1) begin
      o_is_compressed = is_compressed(i_entry0.rdata[15:0]);
      o_valid         = i_valid0;
      w_err           = i_entry0.err;
      o_pop           = !o_is_compressed;
    end else begin
      o_instr         = {i_entry1.rdata[15:0], w_lower};
      o_is_compressed = is_compressed(w_lower);
      o_pop           = 1'b1;
      if (o_is_compressed) begin
        o_valid = i_valid0;
        w_err   = i_entry0.err;
      end else begin
        // A faulting first half is reported without waiting for the second word.
        o_valid     = i_valid0 & (i_valid1 | i_entry0.err);
        w_err       = i_entry0.err | (i_valid1 & i_entry1.err);
        o_err_plus2 = i_valid1 & i_entry1.err & ~i_entry0.err;
      end
    end
  end

  assign o_err = o_valid & w_err;

endmodule

`default_nettype wire

// File: rtl/ibex_fetch_fifo.sv
// ============================================================================
// Module      : ibex_fetch_fifo
// Description : Word-wide fetch FIFO presenting realigned instructions.
//               Optional zero-latency path: IBEX_FETCH_FIFO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_fetch_fifo
  import ibex_fetch_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  output logic [NUM_REQS-1:0] busy_o,
  input  logic                in_valid_i,
  input  logic [31:0]         in_addr_i,
  input  logic [31:0]         in_rdata_i,
  input  logic                in_err_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_addr_o,
  output logic [31:0]         out_rdata_o,
  output logic                out_err_o,
  output logic                out_err_plus2_o
);

  localparam int unsigned DEPTH = NUM_REQS + 1;

  fetch_fifo_entry_t [DEPTH-1:0] r_entries;
  logic              [DEPTH-1:0] r_valid;
  logic              [31:1]      r_addr;

  fetch_fifo_entry_t             w_in_entry;
  fetch_fifo_entry_t [DEPTH:0]   w_ext;
  fetch_fifo_entry_t [DEPTH:0]   w_m_entry;
  logic              [DEPTH:0]   w_m_valid;
  logic              [DEPTH:0]   w_occ_prev;
  logic              [DEPTH:0]   w_occ_cur;
  fetch_fifo_entry_t [DEPTH-1:0] w_entries_n;
  logic              [DEPTH-1:0] w_valid_n;

  fetch_fifo_entry_t w_view0;
  logic              w_view_v0;
  logic              w_push;
  logic              w_out_valid;
  logic              w_is_compressed;
  logic              w_pop;
  logic              w_fire;
  logic              w_do_pop;
  logic              w_unused_addr0;

  assign w_in_entry     = '{rdata: in_rdata_i, err: in_err_i};
  assign w_push         = in_valid_i & ~clear_i;
  assign w_unused_addr0 = in_addr_i[0];

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  logic w_bypass;
  assign w_bypass  = ~r_valid[0] & w_push;
  assign w_view0   = w_bypass ? w_in_entry : r_entries[0];
  assign w_view_v0 = r_valid[0] | w_bypass;
`else
  assign w_view0   = r_entries[0];
  assign w_view_v0 = r_valid[0];
`endif

  ibex_fetch_fifo_align u_align (
    .i_entry0        (w_view0),
    .i_entry1        (r_entries[1]),
    .i_valid0        (w_view_v0),
    .i_valid1        (r_valid[1]),
    .i_addr_bit1     (r_addr[1]),
    .o_instr         (out_rdata_o),
    .o_valid         (w_out_valid),
    .o_err           (out_err_o),
    .o_err_plus2     (out_err_plus2_o),
    .o_is_compressed (w_is_compressed),
    .o_pop           (w_pop)
  );

  assign w_fire   = w_out_valid & out_ready_i;
  assign w_do_pop = w_fire & w_pop;

  // The push lands in a DEPTH+1 scratch array first, so a full FIFO that pops
  // and pushes in the same cycle still keeps the new word after the shift.
  always_comb begin
    w_ext             = '0;
    w_ext[DEPTH-1:0]  = r_entries;
    w_occ_prev        = {r_valid, 1'b1};
    w_occ_cur         = {1'b0, r_valid};
    w_m_entry         = w_ext;
    w_m_valid         = w_occ_cur;
    for (int i = 0; i <= DEPTH; i++) begin
      if (w_push && w_occ_prev[i] && !w_occ_cur[i]) begin
        w_m_entry[i] = w_in_entry;
        w_m_valid[i] = 1'b1;
      end
    end
    w_entries_n = w_do_pop ? w_m_entry[DEPTH:1] : w_m_entry[DEPTH-1:0];
    w_valid_n   = w_do_pop ? w_m_valid[DEPTH:1] : w_m_valid[DEPTH-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_entries <= '0;
      r_valid   <= '0;
      r_addr    <= '0;
    end else if (clear_i) begin
      r_valid   <= '0;
      r_addr    <= in_addr_i[31:1];
    end else begin
      r_entries <= w_entries_n;
      r_valid   <= w_valid_n;
      if (w_fire) begin
        r_addr <= r_addr + (w_is_compressed ? 31'd1 : 31'd2);
      end
    end
  end

  assign out_valid_o = w_out_valid;
  assign out_addr_o  = {r_addr, 1'b0};

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_busy
    assign busy_o[i] = r_valid[i+1];
  end

endmodule

`default_nettype wire

// File: tb/tb_ibex_fetch_fifo.sv
// ============================================================================
// Module      : tb_ibex_fetch_fifo
// Description : Self-checking bench for ibex_fetch_fifo with a halfword-stream
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_fetch_fifo;

  localparam int NUM_REQS = 2;
  localparam int DEPTH    = NUM_REQS + 1;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                clear_i;
  logic [NUM_REQS-1:0] busy_o;
  logic                in_valid_i;
  logic [31:0]         in_addr_i;
  logic [31:0]         in_rdata_i;
  logic                in_err_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [31:0]         out_addr_o;
  logic [31:0]         out_rdata_o;
  logic                out_err_o;
  logic                out_err_plus2_o;

  ibex_fetch_fifo #(.NUM_REQS(NUM_REQS)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .busy_o          (busy_o),
    .in_valid_i      (in_valid_i),
    .in_addr_i       (in_addr_i),
    .in_rdata_i      (in_rdata_i),
    .in_err_i        (in_err_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_addr_o      (out_addr_o),
    .out_rdata_o     (out_rdata_o),
    .out_err_o       (out_err_o),
    .out_err_plus2_o (out_err_plus2_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the instruction stream as a queue of {err, halfword}
  // starting at m_pc; m_skip counts leading halfwords of future words to drop.
  logic [16:0] hq[$];
  logic [31:0] m_pc;
  int          m_skip;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int model_words();
    return (hq.size() + int'(m_pc[1])) / 2;
  endfunction

  task automatic model_expect(output bit v, output bit full32, output logic [31:0] instr,
                              output bit err, output bit p2, output bit comp);
    logic [16:0] h0, h1;
    v = 0; full32 = 0; instr = '0; err = 0; p2 = 0; comp = 0;
    if (hq.size() > 0) begin
      h0   = hq[0];
      comp = (h0[1:0] != 2'b11);
      if (comp) begin
        v = 1; instr = {16'h0, h0[15:0]}; err = h0[16];
      end else if (hq.size() >= 2) begin
        h1 = hq[1];
        v = 1; full32 = 1; instr = {h1[15:0], h0[15:0]};
        err = h0[16] | h1[16]; p2 = h1[16] & ~h0[16];
      end else if (h0[16]) begin
        v = 1; instr = {16'h0, h0[15:0]}; err = 1;
      end
    end
  endtask

  task automatic model_push_half(input logic [15:0] h, input logic e);
    if (m_skip > 0) m_skip--;
    else hq.push_back({e, h});
  endtask

  // Monitor / scoreboard: compare at the falling edge, then advance the model
  // by whatever the upcoming rising edge will commit.
  bit          e_v, e_full, e_err, e_p2, e_comp;
  logic [31:0] e_instr;
  logic [31:0] e_busy;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hq.delete(); m_pc = '0; m_skip = 0;
    end else begin
      model_expect(e_v, e_full, e_instr, e_err, e_p2, e_comp);
      e_busy = '0;
      for (int i = 0; i < NUM_REQS; i++) e_busy[i] = (model_words() > i + 1);
      chk("out_valid", {31'b0, out_valid_o}, {31'b0, e_v});
      chk("busy", {30'b0, busy_o}, e_busy);
      if (e_v && out_valid_o) begin
        chk("out_addr", out_addr_o, m_pc);
        chk("out_rdata", e_full ? out_rdata_o : {16'h0, out_rdata_o[15:0]}, e_instr);
        chk("out_err", {31'b0, out_err_o}, {31'b0, e_err});
        chk("out_err_plus2", {31'b0, out_err_plus2_o}, {31'b0, e_p2});
      end
      assert (clear_i || !in_valid_i || model_words() < DEPTH || (e_v && out_ready_i && !(e_comp && !m_pc[1])));
      if (clear_i) begin
        hq.delete(); m_pc = {in_addr_i[31:1], 1'b0}; m_skip = int'(in_addr_i[1]);
      end else begin
        if (e_v && out_ready_i) begin
          if (e_comp) begin
            void'(hq.pop_front()); m_pc += 32'd2;
          end else if (hq.size() >= 2) begin
            void'(hq.pop_front()); void'(hq.pop_front()); m_pc += 32'd4;
          end else begin
            void'(hq.pop_front()); m_skip++; m_pc += 32'd4;
          end
        end
        if (in_valid_i) begin
          model_push_half(in_rdata_i[15:0], in_err_i);
          model_push_half(in_rdata_i[31:16], in_err_i);
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] d, input bit e, input bit rdy,
                       input bit clr, input logic [31:0] a);
    in_valid_i = v; in_rdata_i = d; in_err_i = e;
    out_ready_i = rdy; clear_i = clr; in_addr_i = a;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input bit rdy);
    drive(0, 32'h0, 0, rdy, 0, 32'h0);
  endtask

  initial begin
    rst_ni = 1'b0;
    in_valid_i = 0; in_rdata_i = '0; in_err_i = 0;
    out_ready_i = 0; clear_i = 0; in_addr_i = '0;
    idle(0); idle(0);
    rst_ni = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid_o}, 32'h0);
    chk("rst_out_err", {31'b0, out_err_o}, 32'h0);
    chk("rst_out_err_plus2", {31'b0, out_err_plus2_o}, 32'h0);
    chk("rst_busy", {30'b0, busy_o}, 32'h0);
    chk("rst_addr", out_addr_o, 32'h0);

    // Aligned 32-bit instruction.
    drive(0, 0, 0, 0, 1, 32'h0000_0080);
    drive(1, 32'h0041_0113, 0, 0, 0, 0);
    idle(1);
    idle(0);
    chk("addr_after_accept", out_addr_o, 32'h0000_0084);

    // Two compressed instructions from one word.
    drive(0, 0, 0, 0, 1, 32'h0000_0100);
    drive(1, 32'h4501_4505, 0, 1, 0, 0);
    idle(1); idle(1); idle(1);

    // Unaligned 32-bit instruction straddling two words.
    drive(0, 0, 0, 0, 1, 32'h0000_0202);
    drive(1, 32'h0113_4505, 0, 1, 0, 0);
    idle(1);
    drive(1, 32'hAAAA_0041, 0, 0, 0, 0);
    idle(1); idle(1); idle(1);

    // Error only in the second word of an unaligned instruction.
    drive(0, 0, 0, 0, 1, 32'h0000_0202);
    drive(1, 32'h0113_0000, 0, 0, 0, 0);
    drive(1, 32'h0000_0041, 1, 0, 0, 0);
    idle(1); idle(1); idle(1);

    // Error in the first word with the second word absent.
    drive(0, 0, 0, 0, 1, 32'h0000_0202);
    drive(1, 32'h0113_0000, 1, 0, 0, 0);
    idle(0); idle(1); idle(1);

    // Fill, then clear with a concurrent push that must be discarded.
    drive(0, 0, 0, 0, 1, 32'h0);
    drive(1, 32'h1111_1113, 0, 0, 0, 0);
    drive(1, 32'h2222_2223, 0, 0, 0, 0);
    drive(1, 32'h3333_3333, 0, 0, 0, 0);
    idle(0);
    drive(1, 32'h4444_4443, 0, 0, 1, 32'h0000_0400);
    idle(0);
    chk("clear_addr", out_addr_o, 32'h0000_0400);
    idle(1);

    // Address wrap past the top of the address space.
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    drive(1, 32'h0041_0113, 0, 1, 0, 0);
    drive(1, 32'h0000_4501, 0, 1, 0, 0);
    idle(1); idle(1); idle(1);

    // Asynchronous reset mid-stream with two words held.
    drive(0, 0, 0, 0, 1, 32'h0000_0040);
    drive(1, 32'h5555_5557, 0, 0, 0, 0);
    drive(1, 32'h6666_6667, 0, 0, 0, 0);
    idle(0);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid_o}, 32'h0);
    chk("midrst_busy", {30'b0, busy_o}, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    chk("midrst_addr", out_addr_o, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      automatic bit          clr = ($urandom_range(0, 39) == 0);
      automatic logic [31:0] a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFA + 32'($urandom_range(0, 5))
                                                               : $urandom;
      automatic logic [31:0] d   = $urandom;
      automatic bit          e   = ($urandom_range(0, 9) == 0);
      automatic bit          rdy = ($urandom_range(0, 9) < 6);
      automatic bit          v   = ($urandom_range(0, 9) < 6) && (model_words() < DEPTH);
      if ($urandom_range(0, 1) == 0) d[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 0) d[17:16] = 2'b11;
      drive(v, d, e, rdy, clr, a);
    end
    idle(1); idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
